// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: RED->GREEN->YELLOW controller with pedestrian GREEN cap and a muxed 2-digit countdown.
// Optional night flash mode: define TRAFFIC_LIGHT_NIGHT_MODE_EN to add the NIGHT input and the FLASH state.
module traffic_light_ctrl #(
   parameter int unsigned CLK_DIV     = 50000000,
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned RED_TIME    = 30,
   parameter int unsigned GREEN_TIME  = 25,
   parameter int unsigned YELLOW_TIME = 3,
   parameter int unsigned PED_SHORT   = 5
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       PED_REQ,
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
   input  logic       NIGHT,
`endif
   output logic       LED_RED,
   output logic       LED_YELLOW,
   output logic       LED_GREEN,
   output logic [6:0] DISP,
   output logic [1:0] DISP_D
);

   localparam int unsigned PW = $clog2(CLK_DIV);
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [6:0]    RED_LD     = 7'(RED_TIME);
   localparam logic [6:0]    GREEN_LD   = 7'(GREEN_TIME);
   localparam logic [6:0]    YELLOW_LD  = 7'(YELLOW_TIME);
   localparam logic [6:0]    SHORT_LD   = 7'(PED_SHORT);

`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
   typedef enum logic [1:0] {ST_RED, ST_GREEN, ST_YELLOW, ST_FLASH} state_t;
`else
   typedef enum logic [1:0] {ST_RED, ST_GREEN, ST_YELLOW} state_t;
`endif

   state_t        state_q, state_d;
   logic [6:0]    remain_q, remain_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [SW-1:0] scan_q, scan_d;
   logic          digit_q, digit_d;
   logic          ped_q, ped_d;
   logic          tick;
   logic          scan_wrap;
   logic [3:0]    digit_val;
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
   logic          flash_q, flash_d;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= ST_RED;
         remain_q <= RED_LD;
         presc_q  <= '0;
         scan_q   <= '0;
         digit_q  <= 1'b0;
         ped_q    <= 1'b0;
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
         flash_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         presc_q  <= presc_d;
         scan_q   <= scan_d;
         digit_q  <= digit_d;
         ped_q    <= ped_d;
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
         flash_q  <= flash_d;
`endif
      end
   end

   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      presc_d   = tick ? '0 : presc_q + PW'(1);
      scan_wrap = (scan_q == SCAN_LAST);
      scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
      digit_d   = digit_q ^ scan_wrap;
      state_d   = state_q;
      remain_d  = remain_q;
      ped_d     = ped_q;
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
      flash_d   = flash_q;
`endif

      case (state_q)
         ST_RED: begin
            if (tick) begin
               if (remain_q == 7'd1) begin
                  state_d  = ST_GREEN;
                  remain_d = GREEN_LD;
               end else begin
                  remain_d = remain_q - 7'd1;
               end
            end
         end
         ST_GREEN: begin
            if (PED_REQ) ped_d = 1'b1;
            if (tick) begin
               if (remain_q == 7'd1) begin
                  state_d  = ST_YELLOW;
                  remain_d = YELLOW_LD;
               end else begin
                  remain_d = remain_q - 7'd1;
               end
            end
            // A flag raised on an earlier edge caps the countdown, winning over this cycle's tick
            if (ped_q && (remain_q > SHORT_LD)) remain_d = SHORT_LD;
         end
         ST_YELLOW: begin
            if (PED_REQ) ped_d = 1'b1;
            if (tick) begin
               if (remain_q == 7'd1) begin
                  state_d  = ST_RED;
                  remain_d = RED_LD;
                  ped_d    = 1'b0;
               end else begin
                  remain_d = remain_q - 7'd1;
               end
            end
         end
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
         ST_FLASH: begin
            if (!NIGHT) begin
               state_d  = ST_RED;
               remain_d = RED_LD;
               presc_d  = '0;
               ped_d    = 1'b0;
            end else if (tick) begin
               flash_d = ~flash_q;
            end
         end
`endif
         default: state_d = ST_RED;
      endcase

`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
      if (NIGHT && (state_q != ST_FLASH)) begin
         state_d  = ST_FLASH;
         remain_d = remain_q;
         presc_d  = '0;
         ped_d    = ped_q;
         flash_d  = 1'b1;
      end
`endif
   end

   always_comb begin
      LED_RED    = (state_q == ST_RED);
      LED_YELLOW = (state_q == ST_YELLOW);
      LED_GREEN  = (state_q == ST_GREEN);
      digit_val  = 4'(digit_q ? (remain_q / 7'd10) : (remain_q % 7'd10));
      DISP_D     = digit_q ? 2'b10 : 2'b01;
      DISP       = (digit_q && (digit_val == 4'd0)) ? 7'b0000000 : seg7(digit_val);
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
      if (state_q == ST_FLASH) begin
         LED_YELLOW = flash_q;
         DISP_D     = 2'b00;
         DISP       = 7'b0000000;
      end
`endif
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: two instances (RED_TIME 3 and 12) against a per-edge phase/countdown model.
`timescale 1ns/1ps
module tb_traffic_light_ctrl;

   localparam int CD = 4;
   localparam int SD = 2;
   localparam int GT = 5;
   localparam int YT = 2;
   localparam int PS = 2;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       ped   = 1'b0;
   logic       night = 1'b0;
   logic       led_r [2];
   logic       led_y [2];
   logic       led_g [2];
   logic [6:0] disp  [2];
   logic [1:0] dd    [2];

   int total = 0;
   int bad   = 0;

   // model state per instance: phase 0=RED 1=GREEN 2=YELLOW 3=FLASH
   int m_ph [2];
   int m_rem[2];
   int m_pc [2];
   int m_sc [2];
   int m_ped[2];
   int m_yl [2];
   int red_t[2] = '{3, 12};
   bit m_valid = 1'b0;
   logic [6:0] seg_tab[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   traffic_light_ctrl #(.CLK_DIV(CD), .SCAN_DIV(SD), .RED_TIME(3), .GREEN_TIME(GT),
                        .YELLOW_TIME(YT), .PED_SHORT(PS)) u_a (
      .CLOCK(clk), .RESET(rst), .PED_REQ(ped),
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
      .NIGHT(night),
`endif
      .LED_RED(led_r[0]), .LED_YELLOW(led_y[0]), .LED_GREEN(led_g[0]),
      .DISP(disp[0]), .DISP_D(dd[0])
   );

   traffic_light_ctrl #(.CLK_DIV(CD), .SCAN_DIV(SD), .RED_TIME(12), .GREEN_TIME(GT),
                        .YELLOW_TIME(YT), .PED_SHORT(PS)) u_b (
      .CLOCK(clk), .RESET(rst), .PED_REQ(ped),
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
      .NIGHT(night),
`endif
      .LED_RED(led_r[1]), .LED_YELLOW(led_y[1]), .LED_GREEN(led_g[1]),
      .DISP(disp[1]), .DISP_D(dd[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dur(input int i, input int ph);
      if (ph == 0) return red_t[i];
      if (ph == 1) return GT;
      return YT;
   endfunction

   task automatic model_step(input int i);
      int  oph, orem, oped;
      bit  tick;
      if (rst) begin
         m_ph[i] = 0; m_rem[i] = red_t[i]; m_pc[i] = 0; m_sc[i] = 0; m_ped[i] = 0; m_yl[i] = 0;
      end else begin
         m_sc[i]++;
         if (night && m_ph[i] != 3) begin
            m_ph[i] = 3; m_pc[i] = 0; m_yl[i] = 1;
         end else if (m_ph[i] == 3) begin
            if (!night) begin
               m_ph[i] = 0; m_rem[i] = red_t[i]; m_pc[i] = 0; m_ped[i] = 0;
            end else begin
               m_pc[i]++;
               if (m_pc[i] % CD == 0) m_yl[i] = 1 - m_yl[i];
            end
         end else begin
            oph = m_ph[i]; orem = m_rem[i]; oped = m_ped[i];
            m_pc[i]++;
            tick = (m_pc[i] % CD == 0);
            if (ped && (oph == 1 || oph == 2)) m_ped[i] = 1;
            if (tick) begin
               if (orem == 1) begin
                  m_ph[i]  = (oph + 1) % 3;
                  m_rem[i] = dur(i, m_ph[i]);
                  if (m_ph[i] == 0) m_ped[i] = 0;
               end else begin
                  m_rem[i] = orem - 1;
               end
            end
            if (oph == 1 && oped == 1 && orem > PS) m_rem[i] = PS;
         end
      end
   endtask

   always @(posedge clk) begin
      if (rst) m_valid = 1'b1;
      for (int i = 0; i < 2; i++) model_step(i);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < 2; i++) begin
            int exp_led, exp_dd, exp_disp, dig, val;
            case (m_ph[i])
               0:       exp_led = 3'b100;
               1:       exp_led = 3'b001;
               2:       exp_led = 3'b010;
               default: exp_led = (m_yl[i] != 0) ? 3'b010 : 3'b000;
            endcase
            if (m_ph[i] == 3) begin
               exp_dd = 0; exp_disp = 0;
            end else begin
               dig      = (m_sc[i] / SD) % 2;
               exp_dd   = dig ? 2 : 1;
               val      = dig ? m_rem[i] / 10 : m_rem[i] % 10;
               exp_disp = (dig && val == 0) ? 0 : int'(seg_tab[val]);
            end
            chk($sformatf("leds%0d", i), {led_r[i], led_y[i], led_g[i]}, exp_led);
            chk($sformatf("disp_d%0d", i), dd[i], exp_dd);
            chk($sformatf("disp%0d", i), disp[i], exp_disp);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; step(2); rst = 1'b0;
      chk("rst_leds_a", {led_r[0], led_y[0], led_g[0]}, 3'b100);
      chk("rst_dd_a", dd[0], 2'b01);
      chk("rst_disp_a", disp[0], 7'b1001111);
      chk("rst_disp_b", disp[1], 7'b1011011);
      step(2);
      chk("tens_dd_b", dd[1], 2'b10);
      chk("tens_disp_b", disp[1], 7'b0000110);
      step(9);  chk("red_end_a", {led_r[0], led_y[0], led_g[0]}, 3'b100);
      step(1);  chk("green_a", {led_r[0], led_y[0], led_g[0]}, 3'b001);
      step(2);  chk("blank_tens_b", disp[1], 7'b0000000);
      step(17); chk("green_end_a", {led_r[0], led_y[0], led_g[0]}, 3'b001);
      step(1);  chk("yellow_a", {led_r[0], led_y[0], led_g[0]}, 3'b010);
      step(7);  chk("yellow_end_a", {led_r[0], led_y[0], led_g[0]}, 3'b010);
      step(1);  chk("red_again_a", {led_r[0], led_y[0], led_g[0]}, 3'b100);

      // pedestrian pulse at GREEN entry of a, while b is still RED
      rst = 1'b1; step(1); rst = 1'b0;
      step(12); ped = 1'b1; step(1); ped = 1'b0;
      step(6);  chk("ped_green_a", {led_r[0], led_y[0], led_g[0]}, 3'b001);
      step(1);  chk("ped_yellow_a", {led_r[0], led_y[0], led_g[0]}, 3'b010);
      step(27); chk("ped_red_b", {led_r[1], led_y[1], led_g[1]}, 3'b100);
      step(1);  chk("ped_green_b", {led_r[1], led_y[1], led_g[1]}, 3'b001);

      // reset mid-GREEN with remain=3
      rst = 1'b1; step(1); rst = 1'b0;
      step(21); rst = 1'b1; step(1); rst = 1'b0;
      chk("midrst_leds_a", {led_r[0], led_y[0], led_g[0]}, 3'b100);
      chk("midrst_disp_a", disp[0], 7'b1001111);
      step(4);  chk("midrst_tick_a", disp[0], 7'b1011011);

`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
      step(5); night = 1'b1; step(1);
      chk("flash_on_a", {led_r[0], led_y[0], led_g[0]}, 3'b010);
      chk("flash_dd_a", dd[0], 2'b00);
      step(3); chk("flash_hold_a", {led_r[0], led_y[0], led_g[0]}, 3'b010);
      step(1); chk("flash_off_a", {led_r[0], led_y[0], led_g[0]}, 3'b000);
      night = 1'b0; step(1);
      chk("flash_exit_a", {led_r[0], led_y[0], led_g[0]}, 3'b100);
`endif

      repeat (3000) begin
         step(1);
         rst = ($urandom_range(0, 299) == 0);
         ped = ($urandom_range(0, 5) == 0);
`ifdef TRAFFIC_LIGHT_NIGHT_MODE_EN
         if ($urandom_range(0, 99) == 0) night = ~night;
`endif
      end
      rst = 1'b0; ped = 1'b0; night = 1'b0;
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parameterised single-intersection traffic-light controller: RED→GREEN→YELLOW cycle with per-phase durations, a two-digit countdown on a multiplexed seven-segment display, and a pedestrian request that shortens GREEN. It is the next generation of the team's two-LED traffic light: it adds a YELLOW phase, configurable timing and pedestrian handling. Same board-level display interface (DISP, DISP_D).

Parameters:
CLK_DIV, 50000000, clock cycles per 1-second tick (≥2)
SCAN_DIV, 50000, clock cycles per display digit slot (≥1)
RED_TIME, 30, RED duration in ticks (1..99)
GREEN_TIME, 25, GREEN duration in ticks (1..99)
YELLOW_TIME, 3, YELLOW duration in ticks (1..99)
PED_SHORT, 5, GREEN remaining-time cap after pedestrian request (1..GREEN_TIME)

Ports:
CLOCK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
PED_REQ  in  1  pedestrian request level, sampled every cycle
LED_RED  out  1  red lamp, 1 = on
LED_YELLOW  out  1  yellow lamp, 1 = on
LED_GREEN  out  1  green lamp, 1 = on
DISP  out  7  segments {g,f,e,d,c,b,a}, 1 = lit
DISP_D  out  2  one-hot digit enable, 2'b01 = ones, 2'b10 = tens

Behaviour:
- Reset is synchronous and active-high: on a rising CLOCK edge with RESET=1, state=RED, remain=RED_TIME, prescaler=0, scan counter=0, digit select=ones, ped_pending=0. Reset mid-phase behaves the same.
- Outputs immediately after reset: LED_RED=1, LED_YELLOW=0, LED_GREEN=0, DISP_D=2'b01, DISP=seg(RED_TIME mod 10).
- Prescaler counts 0..CLK_DIV-1 and wraps. tick=1 for the one cycle when prescaler==CLK_DIV-1. The first tick after reset release occurs on the CLK_DIV-th edge.
- remain is 7 bits. On tick:
  - if remain==1, advance state and load the next phase's duration;
  - otherwise remain decrements by 1.
- Phase length is exactly TIME×CLK_DIV cycles.
- States:
  - RED→GREEN (load GREEN_TIME)
  - GREEN→YELLOW (load YELLOW_TIME)
  - YELLOW→RED (load RED_TIME)
- Exactly one LED is on in each state. LEDs decode combinationally from the state register.
- Pedestrian handling:
  - PED_REQ=1 in GREEN or YELLOW sets ped_pending. PED_REQ is ignored in RED.
  - ped_pending clears on entry to RED.
  - In GREEN, if ped_pending=1 and remain>PED_SHORT, the next edge sets remain=PED_SHORT; this overrides a simultaneous tick decrement.
  - If remain≤PED_SHORT, no effect.
  - A request in the same cycle it is first sampled affects remain one cycle later (flag, then cap).
- Display:
  - Scan counter wraps at SCAN_DIV-1; on wrap, digit select toggles.
  - DISP_D is one-hot from digit select.
  - DISP=seg(remain mod 10) for ones, seg(remain/10) for tens.
  - Tens digit 0 → DISP=7'b0000000 (leading-zero blank).
  - DISP is combinational from remain and digit select and changes the same cycle remain changes.
- Seven-segment codes 0-9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.

Optional Feature:
TRAFFIC_LIGHT_NIGHT_MODE_EN. When defined, an extra input NIGHT (1 bit) is added after PED_REQ.
- NIGHT=1 sampled at an edge: state=FLASH, prescaler reset to 0, LED_RED=LED_GREEN=0.
- In FLASH, LED_YELLOW toggles on each tick, starting at 1 on entry. DISP_D=2'b00 and DISP=0.
- NIGHT=0 while in FLASH: next edge enters RED with remain=RED_TIME and prescaler=0; ped_pending is cleared.
- RESET has priority over NIGHT.
- When not defined: no NIGHT port and no FLASH state.

Test Plan:
All scenarios use CLK_DIV=4, SCAN_DIV=2, RED_TIME=3, GREEN_TIME=5, YELLOW_TIME=2, PED_SHORT=2 unless stated.
1. Assert RESET 2 cycles, release → LED_RED=1, others 0, DISP_D=01, DISP=1001111 (3).
2. Free run from reset release → RED 12 cycles, GREEN 20, YELLOW 8, then RED again at cycle 40. Exactly one LED high at every cycle.
3. RED_TIME=12 → DISP_D alternates 01/10 every 2 cycles; DISP=1011011 on ones, 0000110 on tens. At remain=9, tens slot shows 0000000.
4. PED_REQ pulse at GREEN entry (remain=5) → remain=2 two edges later; GREEN ends after ≤2 more ticks. A PED_REQ pulse in RED leaves RED timing unchanged at 12 cycles.
5. RESET pulse mid-GREEN (remain=3) → next edge LED_RED=1, remain=3, next tick 4 cycles later.
6. With TRAFFIC_LIGHT_NIGHT_MODE_EN: NIGHT=1 → LED_YELLOW toggles every 4 cycles, DISP_D=00. NIGHT=0 → RED with remain=3 next edge.
